// File: rtl/pulse_gen_pkg.sv
// rtl/pulse_gen_pkg.sv - shared types and constants for the pulse train generator
package pulse_gen_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pg_state_t;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_BURST_W = 8;
    localparam int BURST_CONT  = 0;

endpackage

// File: rtl/period_counter.sv
// rtl/period_counter.sv - free-running counter wrapping to zero after reaching limit
module period_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    // wrap must not depend on clear: the owner derives clear from wrap
    assign wrap = enable && (count == limit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= wrap ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - programmable pulse train with burst count and start/stop control
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [WIDTH-1:0]   period,
    input  logic [WIDTH-1:0]   high_len,
    input  logic [BURST_W-1:0] burst_len,
    output logic               pulse,
    output logic               busy,
    output logic               done
);

    pg_state_t          state, state_next;
    logic [WIDTH-1:0]   period_q, high_len_q, count, next_count, next_high;
    logic [BURST_W-1:0] burst_len_q, pcount;
    logic               wrap, go_run, burst_end, burst_mode, last_period, cnt_clear;

    assign burst_mode  = (burst_len_q != BURST_W'(BURST_CONT));
    assign last_period = (pcount == burst_len_q - BURST_W'(1));
    assign busy        = (state == ST_RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        go_run     = 1'b0;
        burst_end  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_next = ST_RUN;
                    go_run     = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (wrap && burst_mode && last_period) begin
                    state_next = ST_IDLE;
                    burst_end  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign cnt_clear = (state == ST_IDLE) || (state_next != ST_RUN);

    period_counter #(.WIDTH(WIDTH)) u_period_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (state == ST_RUN),
        .limit  (period_q),
        .count  (count),
        .wrap   (wrap)
    );

    // Shadows reload only at a boundary so a live pulse is never cut short
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_q    <= '0;
            high_len_q  <= '0;
            burst_len_q <= '0;
            pcount      <= '0;
        end else if (go_run) begin
            period_q    <= period;
            high_len_q  <= high_len;
            burst_len_q <= burst_len;
            pcount      <= '0;
        end else if (state == ST_RUN && wrap) begin
            period_q   <= period;
            high_len_q <= high_len;
            if (burst_mode) pcount <= pcount + BURST_W'(1);
        end
    end

    // pulse is registered from the values count and high_len_q take at this edge
    assign next_count = wrap ? '0 : count + WIDTH'(1);
    assign next_high  = wrap ? high_len : high_len_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pulse <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= burst_end;
            if (go_run)
                pulse <= (high_len != '0);
            else if (state == ST_RUN && state_next == ST_RUN)
                pulse <= (next_count < next_high);
            else
                pulse <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb/tb_pulse_train_gen.sv - directed self-checking bench for pulse_train_gen
module tb_pulse_train_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop;
    logic [7:0] period, high_len, burst_len;
    logic       pulse, busy, done;

    int checks   = 0;
    int failures = 0;

    pulse_train_gen #(.WIDTH(8), .BURST_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .period    (period),
        .high_len  (high_len),
        .burst_len (burst_len),
        .pulse     (pulse),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input logic p, input logic b, input logic d);
        check({tag, ".pulse"}, 32'(pulse), 32'(p));
        check({tag, ".busy"},  32'(busy),  32'(b));
        check({tag, ".done"},  32'(done),  32'(d));
    endtask

    task automatic launch(input logic [7:0] per, input logic [7:0] hi, input logic [7:0] bl);
        period = per; high_len = hi; burst_len = bl; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0;
        period = '0; high_len = '0; burst_len = '0;
        #23;
        outs("reset", 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        outs("idle", 1'b0, 1'b0, 1'b0);

        // continuous 5-cycle period, 2 high
        launch(8'd4, 8'd2, 8'd0);
        for (int i = 0; i < 15; i++) begin
            outs($sformatf("cont[%0d]", i), ((i % 5) < 2), 1'b1, 1'b0);
            step();
        end
        halt();
        outs("cont_stop", 1'b0, 1'b0, 1'b0);

        // burst of 3 periods of 4 cycles
        launch(8'd3, 8'd1, 8'd3);
        for (int i = 0; i < 12; i++) begin
            outs($sformatf("burst[%0d]", i), ((i % 4) == 0), 1'b1, 1'b0);
            step();
        end
        outs("burst_done", 1'b0, 1'b0, 1'b1);
        step();
        outs("burst_after", 1'b0, 1'b0, 1'b0);

        // mid-period high_len change takes effect at the next boundary
        launch(8'd7, 8'd1, 8'd0);
        for (int i = 0; i < 16; i++) begin
            outs($sformatf("reload[%0d]", i), (i < 8) ? (i == 0) : ((i - 8) < 3), 1'b1, 1'b0);
            if (i == 1) high_len = 8'd3;
            step();
        end
        halt();

        // stop at cycle 5, then start+stop together from idle
        launch(8'd9, 8'd8, 8'd0);
        for (int i = 1; i <= 5; i++) begin
            outs($sformatf("stop_run[%0d]", i), 1'b1, 1'b1, 1'b0);
            if (i < 5) step();
        end
        halt();
        outs("stop_c6", 1'b0, 1'b0, 1'b0);
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        outs("start_stop", 1'b0, 1'b0, 1'b0);
        step();
        outs("start_stop2", 1'b0, 1'b0, 1'b0);

        // high_len 0: never pulses
        launch(8'd3, 8'd0, 8'd2);
        for (int i = 0; i < 8; i++) begin
            outs($sformatf("hi0[%0d]", i), 1'b0, 1'b1, 1'b0);
            step();
        end
        outs("hi0_done", 1'b0, 1'b0, 1'b1);

        // high_len beyond period: full duty
        launch(8'd5, 8'd12, 8'd0);
        for (int i = 0; i < 14; i++) begin
            outs($sformatf("full[%0d]", i), 1'b1, 1'b1, 1'b0);
            step();
        end
        halt();
        outs("full_stop", 1'b0, 1'b0, 1'b0);

        // period 0 burst 4, then restart on the done cycle
        launch(8'd0, 8'd1, 8'd4);
        for (int i = 0; i < 4; i++) begin
            outs($sformatf("p0[%0d]", i), 1'b1, 1'b1, 1'b0);
            step();
        end
        outs("p0_done", 1'b0, 1'b0, 1'b1);
        launch(8'd0, 8'd1, 8'd1);
        outs("restart", 1'b1, 1'b1, 1'b0);
        step();
        outs("restart_done", 1'b0, 1'b0, 1'b1);
        step();

        // async reset mid-burst, then a fresh full burst
        launch(8'd3, 8'd2, 8'd3);
        for (int i = 0; i < 5; i++) step();
        outs("pre_rst", 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        outs("async_rst", 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        outs("post_rst", 1'b0, 1'b0, 1'b0);
        launch(8'd3, 8'd2, 8'd3);
        for (int i = 0; i < 12; i++) begin
            outs($sformatf("fresh[%0d]", i), ((i % 4) < 2), 1'b1, 1'b0);
            step();
        end
        outs("fresh_done", 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Programmable pulse-train generator: one free-running period counter produces a pulse of configurable high time, either continuously or as a counted burst. It extends the single-period enable-value pulse block with duty-cycle control, burst counting, a start/stop handshake and glitch-free reconfiguration. It sits beside the timing/strobe logic and drives sample strobes and test stimulus.

## Interface
- `WIDTH`, default 8: width of the period and high-time counters.
- `BURST_W`, default 8: width of the burst-length counter.
- `clk` in, 1: clock, rising edge.
- `rst` in, 1: reset, asynchronous, active-low.
- `start` in, 1: single-cycle request to begin a train. Honoured only in IDLE.
- `stop` in, 1: abort request. Honoured in RUN.
- `period` in, WIDTH: period length is `period+1` cycles.
- `high_len` in, WIDTH: number of high cycles per period. 0 means no pulse.
- `burst_len` in, BURST_W: number of periods to run. 0 means continuous.
- `pulse` out, 1: registered pulse output.
- `busy` out, 1: high while in RUN.
- `done` out, 1: one-cycle strobe when a burst completes naturally.

## Operation
- FSM has two states: IDLE and RUN. Reset puts the block in IDLE with `count`=0, `pcount`=0, `pulse`=0, `busy`=0, `done`=0, and all shadow registers at 0.
- IDLE to RUN: on `start`=1 with `stop`=0.
  - Shadow registers capture `period`, `high_len` and `burst_len`.
  - `count` is set to 0 and `pcount` to 0.
- In RUN, `count` increments each cycle. When `count`==`period_q` it wraps to 0; this is the period boundary.
  - At each boundary `period_q` and `high_len_q` reload from the inputs. Mid-period input changes therefore never truncate or glitch a pulse.
  - `burst_len_q` is latched only at start.
- `pulse` is high exactly when `count` < `high_len_q`, evaluated on the registered count. If `high_len_q` > `period_q`, `pulse` stays high for the whole period, which gives 100 % duty.
- Burst mode (`burst_len_q` != 0): `pcount` increments at each boundary.
  - At the boundary where `pcount`==`burst_len_q`-1, the FSM returns to IDLE.
  - `done`=1 for one cycle and `pulse`=0.
- Continuous mode (`burst_len_q`==0): `pcount` is held at 0 and the block runs until `stop`.
- `stop` in RUN: the FSM goes to IDLE at the next edge and `pulse`=0. `done` is not asserted.
- Priority rules:
  - `stop` beats `start` in the same cycle.
  - `start` during RUN is ignored.
  - `start` on the same cycle as `done` (already IDLE) is honoured.
- Asynchronous reset mid-train: all outputs go to reset values immediately. No `done` is produced.
- Arithmetic: all comparisons are unsigned. Counters wrap at the natural width but never exceed their shadowed limits.

## Timing
- `start` sampled at edge t: `busy`=1 and `count`=0 from t+1. `pulse`=1 from t+1 if `high_len`>0.
- Output latency is 1 cycle from `start`.
- Period = `period+1` cycles. High time = min(`high_len`, `period+1`) cycles.
- Burst of N periods: `busy` lasts N·(`period_q`+1) cycles. `done` and `busy`=0 appear together on the cycle after the last count of the final period.
- `stop` sampled at edge s: `busy`=0 and `pulse`=0 from s+1.
- `period`=0: every cycle is a boundary. `pulse` is constant high if `high_len`≥1.

## Structure
- Package `pulse_gen_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_RUN`);
  - the default widths;
  - the helper constant for continuous burst (0).
- Sub-module `period_counter` (WIDTH): clear, enable, and a limit input. It outputs `count` and a `wrap` strobe. It is instantiated once for the period count. `pcount` lives inline.
- The top level owns the FSM, the shadow registers, the pulse comparator and the `done` strobe.

## Test plan
- Reset, then `period`=4, `high_len`=2, `burst_len`=0, `start` → `pulse` repeats 1,1,0,0,0 from the cycle after `start`. `busy` stays 1 and `done` never fires.
- `period`=3, `high_len`=1, `burst_len`=3, `start` → exactly 3 pulses over 12 cycles. `done`=1 for one cycle on cycle 13 with `busy`=0.
- Change `high_len` from 1 to 3 mid-period with `period`=7 → the current period keeps a 1-cycle pulse and the next period has a 3-cycle pulse.
- `stop` at cycle 5 of a continuous train with `period`=9, `high_len`=8 → `pulse` and `busy` are 0 at cycle 6 with no `done`. `start` and `stop` asserted together from IDLE → the block stays IDLE.
- Edge values:
  - `high_len`=0 → `pulse` never rises.
  - `high_len`=12 with `period`=5 → `pulse` stays high throughout.
  - `period`=0 with `burst_len`=4 → `busy` lasts 4 cycles, then `done`.
- Assert `rst` low mid-burst → outputs clear immediately. After release, `start` runs a full fresh burst.
